id_stage: RTL and testbench



---
 rtl/id_stage.sv | 183 ++++++++++++++++++
 tb/tb_id_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Instruction-decode stage of a 5-stage MIPS pipeline.
// Holds the IF/ID register and the 32x32 register file, decodes control,
// detects load-use and branch hazards, and resolves beq/bne/j early so IF
// can be stalled or redirected in the same cycle.
module id_stage (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_instruction,
    input  logic [31:0] i_pc_plus4,
    input  logic        i_wb_write_en,
    input  logic [4:0]  i_wb_write_addr,
    input  logic [31:0] i_wb_write_data,
    input  logic        i_ex_reg_write,
    input  logic        i_ex_mem_read,
    input  logic [4:0]  i_ex_write_reg,
    input  logic        i_mem_reg_write,
    input  logic [4:0]  i_mem_write_reg,
    output logic        o_stall,
    output logic        o_bubble,
    output logic        o_pc_src,
    output logic [31:0] o_pc_target,
    output logic [31:0] o_rs_data,
    output logic [31:0] o_rt_data,
    output logic [31:0] o_imm_ext,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt,
    output logic [4:0]  o_rd,
    output logic [5:0]  o_funct,
    output logic [31:0] o_pc_plus4,
    output logic        o_reg_write,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic        o_mem_to_reg,
    output logic        o_alu_src,
    output logic        o_reg_dst,
    output logic [2:0]  o_alu_op
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // ALU operation classes handed to EX
    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;
    localparam logic [2:0] ALU_SLT   = 3'd3;
    localparam logic [2:0] ALU_AND   = 3'd4;
    localparam logic [2:0] ALU_OR    = 3'd5;
    localparam logic [2:0] ALU_LUI   = 3'd6;

    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [31:0] regs [32];

    logic [5:0]  opcode;
    logic [4:0]  rs, rt;
    logic [15:0] imm16;
    logic [31:0] imm_sext;
    logic [31:0] rs_data, rt_data;
    logic        is_j, is_beq, is_bne, is_branch, rt_is_src;
    logic        load_use, branch_hz, stall, pc_src, rs_eq_rt;
    logic [31:0] branch_target, jump_target;

    // IF/ID register: stall holds, redirect flushes to a NOP, else capture IF
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ifid_instr <= '0;
            ifid_pc4   <= '0;
            ifid_valid <= 1'b0;
        end else if (stall) begin
            ifid_instr <= ifid_instr;
        end else if (pc_src) begin
            ifid_instr <= '0;
            ifid_valid <= 1'b0;
        end else begin
            ifid_instr <= i_instruction;
            ifid_pc4   <= i_pc_plus4;
            ifid_valid <= 1'b1;
        end
    end

    // Register file write port; r0 is never written
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (i_wb_write_en && i_wb_write_addr != 5'd0) begin
            regs[i_wb_write_addr] <= i_wb_write_data;
        end
    end

    assign opcode   = ifid_instr[31:26];
    assign rs       = ifid_instr[25:21];
    assign rt       = ifid_instr[20:16];
    assign imm16    = ifid_instr[15:0];
    assign imm_sext = {{16{imm16[15]}}, imm16};

    // Read ports with same-cycle write-back bypass so WB and ID overlap
    always_comb begin
        rs_data = regs[rs];
        rt_data = regs[rt];
        if (i_wb_write_en && i_wb_write_addr != 5'd0 && i_wb_write_addr == rs)
            rs_data = i_wb_write_data;
        if (i_wb_write_en && i_wb_write_addr != 5'd0 && i_wb_write_addr == rt)
            rt_data = i_wb_write_data;
        if (rs == 5'd0) rs_data = '0;
        if (rt == 5'd0) rt_data = '0;
    end

    // Control decode; invalid slots and unknown opcodes decode as a NOP
    always_comb begin
        o_reg_write  = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_mem_to_reg = 1'b0;
        o_alu_src    = 1'b0;
        o_reg_dst    = 1'b0;
        o_alu_op     = ALU_ADD;
        if (ifid_valid) begin
            case (opcode)
                OP_RTYPE: begin o_reg_write = 1'b1; o_reg_dst = 1'b1; o_alu_op = ALU_FUNCT; end
                OP_LW:    begin o_reg_write = 1'b1; o_mem_read = 1'b1; o_mem_to_reg = 1'b1; o_alu_src = 1'b1; end
                OP_SW:    begin o_mem_write = 1'b1; o_alu_src = 1'b1; end
                OP_BEQ,
                OP_BNE:   o_alu_op = ALU_SUB;
                OP_ADDI:  begin o_reg_write = 1'b1; o_alu_src = 1'b1; end
                OP_SLTI:  begin o_reg_write = 1'b1; o_alu_src = 1'b1; o_alu_op = ALU_SLT; end
                OP_ANDI:  begin o_reg_write = 1'b1; o_alu_src = 1'b1; o_alu_op = ALU_AND; end
                OP_ORI:   begin o_reg_write = 1'b1; o_alu_src = 1'b1; o_alu_op = ALU_OR; end
                OP_LUI:   begin o_reg_write = 1'b1; o_alu_src = 1'b1; o_alu_op = ALU_LUI; end
                default:  o_alu_op = ALU_ADD;
            endcase
        end
    end

    assign is_j      = ifid_valid && opcode == OP_J;
    assign is_beq    = ifid_valid && opcode == OP_BEQ;
    assign is_bne    = ifid_valid && opcode == OP_BNE;
    assign is_branch = is_beq || is_bne;
    assign rt_is_src = opcode == OP_RTYPE || opcode == OP_SW || is_branch;

    assign load_use = i_ex_mem_read && i_ex_write_reg != 5'd0 &&
                      (i_ex_write_reg == rs || (rt_is_src && i_ex_write_reg == rt));

    // The comparator has no forwarding, so any producer still in EX or MEM
    // must drain to WB (where the read bypass catches it) before resolving.
    assign branch_hz = is_branch && (
        (i_ex_reg_write && i_ex_write_reg != 5'd0 &&
         (i_ex_write_reg == rs || i_ex_write_reg == rt)) ||
        (i_mem_reg_write && i_mem_write_reg != 5'd0 &&
         (i_mem_write_reg == rs || i_mem_write_reg == rt)));

    assign stall    = ifid_valid && (load_use || branch_hz);
    assign rs_eq_rt = rs_data == rt_data;
    assign pc_src   = ifid_valid && !stall &&
                      (is_j || (is_beq && rs_eq_rt) || (is_bne && !rs_eq_rt));

    assign branch_target = ifid_pc4 + {imm_sext[29:0], 2'b00};
    assign jump_target   = {ifid_pc4[31:28], ifid_instr[25:0], 2'b00};

    assign o_stall     = stall;
    assign o_bubble    = stall;
    assign o_pc_src    = pc_src;
    assign o_pc_target = is_j ? jump_target : branch_target;
    assign o_rs_data   = rs_data;
    assign o_rt_data   = rt_data;
    assign o_imm_ext   = (opcode == OP_ANDI || opcode == OP_ORI) ? {16'h0000, imm16} : imm_sext;
    assign o_rs        = rs;
    assign o_rt        = rt;
    assign o_rd        = ifid_instr[15:11];
    assign o_funct     = ifid_instr[5:0];
    assign o_pc_plus4  = ifid_pc4;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: stimulus computes the expected decode
// outputs from an architectural model and queues them; a monitor compares.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr, pc4, wb_data;
    logic        wb_en, ex_rw, ex_mr, mem_rw;
    logic [4:0]  wb_addr, ex_wr, mem_wr;
    logic        stall, bubble, pc_src, reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst;
    logic [31:0] pc_target, rs_data, rt_data, imm_ext, pc_plus4;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [2:0]  alu_op;

    always #5 clk = ~clk;

    id_stage dut (
        .i_clk(clk), .i_reset(rst), .i_instruction(instr), .i_pc_plus4(pc4),
        .i_wb_write_en(wb_en), .i_wb_write_addr(wb_addr), .i_wb_write_data(wb_data),
        .i_ex_reg_write(ex_rw), .i_ex_mem_read(ex_mr), .i_ex_write_reg(ex_wr),
        .i_mem_reg_write(mem_rw), .i_mem_write_reg(mem_wr),
        .o_stall(stall), .o_bubble(bubble), .o_pc_src(pc_src), .o_pc_target(pc_target),
        .o_rs_data(rs_data), .o_rt_data(rt_data), .o_imm_ext(imm_ext),
        .o_rs(rs), .o_rt(rt), .o_rd(rd), .o_funct(funct), .o_pc_plus4(pc_plus4),
        .o_reg_write(reg_write), .o_mem_read(mem_read), .o_mem_write(mem_write),
        .o_mem_to_reg(mem_to_reg), .o_alu_src(alu_src), .o_reg_dst(reg_dst), .o_alu_op(alu_op)
    );

    typedef struct packed {
        logic        stall;
        logic        pc_src;
        logic [31:0] target;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [84:0] fields;  // imm, rs, rt, rd, funct, pc+4
        logic [8:0]  ctrl;    // reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op
    } exp_t;

    exp_t        sb [$];
    int          n_cmp = 0, n_bad = 0;

    // architectural model state
    logic [31:0] m_regs [32];
    logic [31:0] m_instr, m_pc4;
    logic        m_valid;

    function automatic logic [31:0] rtype(input int s, t, d, f);
        return {6'h00, 5'(s), 5'(t), 5'(d), 5'd0, 6'(f)};
    endfunction
    function automatic logic [31:0] itype(input int op, s, t, imm);
        return {6'(op), 5'(s), 5'(t), 16'(imm)};
    endfunction

    function automatic logic [31:0] rdreg(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (wb_en && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int   op = int'(m_instr[31:26]);
        logic [4:0] s = m_instr[25:21], t = m_instr[20:16];
        logic [31:0] a = rdreg(s), b = rdreg(t);
        logic [15:0] im = m_instr[15:0];
        logic [31:0] imx;
        logic  rt_src, lu, hz, br, take;
        logic [8:0] c;
        case (op)
            'h00: c = {6'b100001, 3'd2};
            'h23: c = {6'b110110, 3'd0};
            'h2B: c = {6'b001010, 3'd0};
            'h04, 'h05: c = {6'b000000, 3'd1};
            'h08: c = {6'b100010, 3'd0};
            'h0A: c = {6'b100010, 3'd3};
            'h0C: c = {6'b100010, 3'd4};
            'h0D: c = {6'b100010, 3'd5};
            'h0F: c = {6'b100010, 3'd6};
            default: c = '0;
        endcase
        if (!m_valid) c = '0;
        br     = m_valid && (op == 'h04 || op == 'h05);
        rt_src = op == 'h00 || op == 'h2B || br;
        lu     = ex_mr && ex_wr != 0 && (ex_wr == s || (rt_src && ex_wr == t));
        hz     = (ex_rw && ex_wr != 0 && (ex_wr == s || ex_wr == t)) ||
                 (mem_rw && mem_wr != 0 && (mem_wr == s || mem_wr == t));
        e.stall = m_valid && (lu || (br && hz));
        take    = op == 'h02 || (op == 'h04 && a == b) || (op == 'h05 && a != b);
        e.pc_src = m_valid && !e.stall && take;
        if (m_valid && op == 'h02) e.target = {m_pc4[31:28], m_instr[25:0], 2'b00};
        else e.target = m_pc4 + 32'($signed(im) * 4);
        imx = (op == 'h0C || op == 'h0D) ? {16'd0, im} : 32'($signed(im));
        e.rsd = a;
        e.rtd = b;
        e.fields = {imx, s, t, m_instr[15:11], m_instr[5:0], m_pc4};
        e.ctrl = c;
        return e;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
    endtask

    // one cycle of stimulus, entered and left at a falling edge
    task automatic cyc(input logic [31:0] ins, p4, input logic we, input int wa,
                       input logic [31:0] wd, input logic exrw, exmr, input int exwr,
                       input logic mrw, input int mwr);
        exp_t e;
        instr = ins; pc4 = p4; wb_en = we; wb_addr = 5'(wa); wb_data = wd;
        ex_rw = exrw; ex_mr = exmr; ex_wr = 5'(exwr); mem_rw = mrw; mem_wr = 5'(mwr);
        e = model_out();
        sb.push_back(e);
        @(posedge clk);
        if (we && wa != 0) m_regs[wa] = wd;
        if (!e.stall) begin
            if (e.pc_src) begin m_instr = '0; m_valid = 1'b0; end
            else begin m_instr = ins; m_pc4 = p4; m_valid = 1'b1; end
        end
        @(negedge clk);
    endtask

    task automatic nop(input logic we = 0, input int wa = 0, input logic [31:0] wd = 0);
        cyc(32'd0, 32'h100, we, wa, wd, 0, 0, 0, 0, 0);
    endtask

    // assert reset mid-cycle, check it clears at once, release at the next falling edge
    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        sb.push_back(model_out());
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // monitor: compare DUT outputs against queued expectations mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("stall", 128'(stall), 128'(e.stall));
                chk("bubble", 128'(bubble), 128'(e.stall));
                chk("pc_src", 128'(pc_src), 128'(e.pc_src));
                chk("pc_target", 128'(pc_target), 128'(e.target));
                chk("rs_data", 128'(rs_data), 128'(e.rsd));
                chk("rt_data", 128'(rt_data), 128'(e.rtd));
                chk("fields", 128'({imm_ext, rs, rt, rd, funct, pc_plus4}), 128'(e.fields));
                chk("ctrl", 128'({reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op}),
                    128'(e.ctrl));
            end
        end
    end

    initial begin
        int ops [12] = '{'h00, 'h23, 'h2B, 'h04, 'h05, 'h08, 'h0A, 'h0C, 'h0D, 'h0F, 'h02, 'h3F};
        logic [31:0] ins;
        int op;
        rst = 1'b1; instr = '0; pc4 = '0; wb_en = 0; wb_addr = 0; wb_data = 0;
        ex_rw = 0; ex_mr = 0; ex_wr = 0; mem_rw = 0; mem_wr = 0;
        model_clear();
        @(negedge clk);
        do_reset();

        // seed r1 = r2 = 7
        nop(1, 1, 32'd7);
        nop(1, 2, 32'd7);
        // write-back bypass into rs, and a write to r0 that must be ignored
        cyc(rtype(5, 0, 6, 'h20), 32'h8, 0, 0, 0, 0, 0, 0, 0, 0);
        nop(1, 5, 32'hDEADBEEF);
        cyc(rtype(0, 0, 7, 'h20), 32'hC, 0, 0, 0, 0, 0, 0, 0, 0);
        nop(1, 0, 32'h1234);
        // load-use: lw r8 in EX while add r9,r8,r10 sits in ID
        cyc(rtype(8, 10, 9, 'h20), 32'h10, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(32'd0, 32'h14, 0, 0, 0, 1, 1, 8, 0, 0);
        nop();
        // beq taken (+3 from 0x14 -> 0x20) followed by the flushed slot
        cyc(itype('h04, 1, 2, 3), 32'h14, 0, 0, 0, 0, 0, 0, 0, 0);
        nop();
        nop();
        // bne not taken, then j 0x100 from 0x10000004
        cyc(itype('h05, 1, 2, 5), 32'h18, 0, 0, 0, 0, 0, 0, 0, 0);
        nop();
        cyc({6'h02, 26'h0000100}, 32'h10000004, 0, 0, 0, 0, 0, 0, 0, 0);
        nop();
        nop();
        // branch hazard: producer of r1 passes through EX, MEM, then WB
        cyc(itype('h04, 1, 2, 'hFFFE), 32'h40, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(32'd0, 32'h44, 0, 0, 0, 1, 0, 1, 0, 0);
        cyc(32'd0, 32'h44, 0, 0, 0, 0, 0, 0, 1, 1);
        nop(1, 1, 32'd7);
        nop();
        // reset mid-stream, then every register must read back as zero
        nop(1, 3, 32'h55);
        do_reset();
        for (int i = 1; i < 32; i++) cyc(rtype(i, i, 0, 'h20), 32'h4, 0, 0, 0, 0, 0, 0, 0, 0);
        nop();

        // randomized traffic with small register indices to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                continue;
            end
            op = ops[$urandom_range(0, 11)];
            if (op == 'h02) ins = {6'h02, 26'($urandom)};
            else if (op == 'h00) ins = rtype($urandom_range(0, 7), $urandom_range(0, 7),
                                             $urandom_range(0, 31), $urandom_range(0, 63));
            else ins = itype(op, $urandom_range(0, 7), $urandom_range(0, 7),
                             ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 15)) : int'($urandom));
            cyc(ins, $urandom, 1'($urandom), $urandom_range(0, 7),
                ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom,
                1'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 7),
                1'($urandom), $urandom_range(0, 7));
        end

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() > 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
